// File: rtl/mode_selector_n.sv
// Mode selector: synchronised, debounced buttons with auto-repeat drive a
// wrapping user mode 1..NUM_MODES and an edit mode that saves and restores it.
module mode_selector_n_btn #(
  parameter int DEB     = 4,
  parameter int RDELAY  = 0,
  parameter int RPERIOD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic press_o
);
  localparam int CW   = (DEB > 1) ? $clog2(DEB) : 1;
  localparam int RMAX = (RDELAY > RPERIOD) ? RDELAY : RPERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [1:0]    sync_q;
  logic          lvl_q, lvl_d, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rpt_q, rpt_d;
  logic          first_q, first_d;
  logic          rep;

  // rpt_q counts cycles since the last (initial or repeat) press while held
  assign rep     = (RDELAY > 0) && lvl_q &&
                   (rpt_q == (first_q ? RW'(RPERIOD) : RW'(RDELAY)));
  assign press_o = (lvl_q & ~prev_q) | rep;

  always_comb begin
    lvl_d   = lvl_q;
    cnt_d   = '0;
    rpt_d   = '0;
    first_d = 1'b0;
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == CW'(DEB - 1)) lvl_d = sync_q[1];
      else                       cnt_d = cnt_q + 1'b1;
    end
    if (lvl_q && RDELAY > 0) begin
      if (rep) begin
        rpt_d   = RW'(1);
        first_d = 1'b1;
      end else begin
        rpt_d   = rpt_q + 1'b1;
        first_d = first_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      lvl_q   <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      rpt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      lvl_q   <= lvl_d;
      prev_q  <= lvl_q;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
      first_q <= first_d;
    end
  end
endmodule

module mode_selector_n #(
  parameter int NUM_MODES       = 7,
  parameter int MODE_W          = 4,
  parameter int EDIT_MODE       = 0,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up,
  input  logic              down,
  input  logic              modify,
  output logic [MODE_W-1:0] rel,
  output logic [MODE_W-1:0] saved_mode,
  output logic              edit_active,
  output logic              mode_changed
);
  localparam logic [0:0] S_NORMAL = 1'b0;
  localparam logic [0:0] S_EDIT   = 1'b1;
  localparam int NBTN = 3;

  logic [NBTN-1:0]   raw, press;
  logic [MODE_W-1:0] rel_q, rel_d, saved_q, saved_d;
  logic [0:0]        state_q, state_d;
  logic              chg_q;

  assign raw = {modify, down, up};

  // modify (index 2) never auto-repeats
  generate
    for (genvar i = 0; i < NBTN; i++) begin : g_btn
      mode_selector_n_btn #(
        .DEB     (DEBOUNCE_CYCLES),
        .RDELAY  ((i == 2) ? 0 : REPEAT_DELAY),
        .RPERIOD (REPEAT_PERIOD)
      ) u_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_i   (raw[i]),
        .press_o (press[i])
      );
    end
  endgenerate

  always_comb begin
    rel_d   = rel_q;
    saved_d = saved_q;
    state_d = state_q;
    if (state_q == S_NORMAL) begin
      if (press[2]) begin
        saved_d = rel_q;
        rel_d   = MODE_W'(EDIT_MODE);
        state_d = S_EDIT;
      end else if (press[0] && !press[1]) begin
        rel_d = (rel_q == MODE_W'(NUM_MODES)) ? MODE_W'(1) : rel_q + MODE_W'(1);
      end else if (press[1] && !press[0]) begin
        rel_d = (rel_q == MODE_W'(1)) ? MODE_W'(NUM_MODES) : rel_q - MODE_W'(1);
      end
    end else if (press[2]) begin
      rel_d   = saved_q;
      state_d = S_NORMAL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rel_q   <= MODE_W'(1);
      saved_q <= MODE_W'(1);
      state_q <= S_NORMAL;
      chg_q   <= 1'b0;
    end else begin
      rel_q   <= rel_d;
      saved_q <= saved_d;
      state_q <= state_d;
      chg_q   <= (rel_d != rel_q);
    end
  end

  assign rel          = rel_q;
  assign saved_mode   = saved_q;
  assign edit_active  = (state_q == S_EDIT);
  assign mode_changed = chg_q;
endmodule

// File: tb/tb_mode_selector_n.sv
// Scoreboard bench: stimulus pushes expected (rel, saved_mode, edit_active)
// per mode change; monitors pop on every mode_changed pulse.
module tb_mode_selector_n;
  typedef struct packed {
    logic [3:0] rel;
    logic [3:0] sv;
    logic       ed;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a, up_a, dn_a, md_a;
  logic [3:0] rel_a, sv_a;
  logic ed_a, mc_a;
  logic rst_n_b, up_b, dn_b, md_b;
  logic [3:0] rel_b, sv_b;
  logic ed_b, mc_b;

  mode_selector_n #(.REPEAT_DELAY(0)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .up(up_a), .down(dn_a), .modify(md_a),
    .rel(rel_a), .saved_mode(sv_a), .edit_active(ed_a), .mode_changed(mc_a));

  mode_selector_n #(.REPEAT_DELAY(16), .REPEAT_PERIOD(8)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .up(up_b), .down(dn_b), .modify(md_b),
    .rel(rel_b), .saved_mode(sv_b), .edit_active(ed_b), .mode_changed(mc_b));

  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  always @(negedge clk) begin
    if (rst_n_a === 1'b1 && mc_a === 1'b1) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL chg_a unexpected pulse: rel=%0d saved=%0d edit=%0d", rel_a, sv_a, ed_a);
      end else begin
        ea = qa.pop_front();
        if (rel_a !== ea.rel || sv_a !== ea.sv || ed_a !== ea.ed) begin
          errors++;
          $display("FAIL chg_a got rel=%0d saved=%0d edit=%0d want rel=%0d saved=%0d edit=%0d",
                   rel_a, sv_a, ed_a, ea.rel, ea.sv, ea.ed);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n_b === 1'b1 && mc_b === 1'b1) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL chg_b unexpected pulse: rel=%0d", rel_b);
      end else begin
        eb = qb.pop_front();
        if (rel_b !== eb.rel || sv_b !== eb.sv || ed_b !== eb.ed) begin
          errors++;
          $display("FAIL chg_b got rel=%0d saved=%0d edit=%0d want rel=%0d saved=%0d edit=%0d",
                   rel_b, sv_b, ed_b, eb.rel, eb.sv, eb.ed);
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  // mask bits: 0=up 1=down 2=modify
  task automatic press_a(input logic [2:0] m, input int hold);
    {md_a, dn_a, up_a} = m;
    tick(hold);
    {md_a, dn_a, up_a} = 3'b000;
    tick(10);
  endtask

  task automatic push_a(input int r, input int s, input logic e);
    qa.push_back({4'(r), 4'(s), e});
  endtask

  initial begin
    rst_n_a = 1'b0; up_a = 1'b1; dn_a = 1'b0; md_a = 1'b0;
    rst_n_b = 1'b0; up_b = 1'b0; dn_b = 1'b0; md_b = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("rst_rel", int'(rel_a), 1);
      chk("rst_edit_mc", int'({ed_a, mc_a}), 0);
    end
    up_a = 1'b0;
    rst_n_a = 1'b1;
    tick(10);

    // glitch one cycle short of the debounce window
    up_a = 1'b1;
    tick(3);
    up_a = 1'b0;
    tick(12);
    chk("glitch_rel", int'(rel_a), 1);

    // clean press: latency DEBOUNCE_CYCLES+3 = 7 edges
    push_a(2, 1, 1'b0);
    up_a = 1'b1;
    tick(6);
    chk("lat_edge6", int'(rel_a), 1);
    tick(1);
    chk("lat_edge7", int'(rel_a), 2);
    tick(13);
    up_a = 1'b0;
    tick(10);

    for (int r = 3; r <= 7; r++) begin
      push_a(r, 1, 1'b0);
      press_a(3'b001, 10);
    end
    push_a(1, 1, 1'b0); press_a(3'b001, 10);
    push_a(7, 1, 1'b0); press_a(3'b010, 10);
    press_a(3'b011, 10);
    chk("updown_same", int'(rel_a), 7);
    push_a(6, 1, 1'b0); press_a(3'b010, 10);
    push_a(5, 1, 1'b0); press_a(3'b010, 10);

    push_a(0, 5, 1'b1); press_a(3'b100, 10);
    press_a(3'b001, 10);
    chk("edit_up_ign", int'(rel_a), 0);
    push_a(5, 5, 1'b0); press_a(3'b100, 10);

    push_a(4, 5, 1'b0); press_a(3'b010, 10);
    push_a(3, 5, 1'b0); press_a(3'b010, 10);
    push_a(0, 3, 1'b1); press_a(3'b101, 10);
    chk("prio_edit", int'(ed_a), 1);

    rst_n_a = 1'b0;
    tick(1);
    chk("edit_rst_rel", int'(rel_a), 1);
    chk("edit_rst_edit", int'(ed_a), 0);
    rst_n_a = 1'b1;
    tick(5);

    // long hold without repeat: single step
    push_a(2, 1, 1'b0);
    press_a(3'b001, 38);
    chk("norpt_rel", int'(rel_a), 2);

    // repeat instance: first press +16, +24, +32 within the hold
    rst_n_b = 1'b1;
    tick(5);
    for (int r = 2; r <= 5; r++) qb.push_back({4'(r), 4'd1, 1'b0});
    up_b = 1'b1;
    tick(38);
    up_b = 1'b0;
    tick(20);
    chk("rpt_rel", int'(rel_b), 5);

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
